key_lock_ctrl: RTL
==================

// Module: key_lock_ctrl
// PURPOSE
//  Sequential key manager for locked netlists such as the c432 family: the XOR
//  key gates on primary I/O and the 4:1 mux-LUT key cells.
//  - Receives a serial key frame and checks it against a CRC signature.
//  - Applies the key to the locked core only when the check passes.
//  - Enters a permanent lockout after repeated failed frames.
//  Sits between the key-provisioning interface and the key inputs of the locked core.
// PARAMETERS
//  N_XOR     34       number of XOR key bits (xor_key)
//  N_MUX     4        number of mux-LUT key bits (mux_key)
//  SIG_W     16       CRC signature width
//  CRC_POLY  16'h1021 CRC polynomial (SIG_W bits); CRC init value is all ones
//  MAX_FAILS 3        failed frames tolerated before permanent lockout (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  load_start   in   1        pulse: begin a new key frame
//  key_clr      in   1        pulse: zeroise active key, abort any load
//  key_in_valid in   1        serial bit valid
//  key_in_bit   in   1        serial key/signature bit
//  key_in_ready out  1        block accepts a bit this cycle
//  xor_key      out  N_XOR    applied XOR key
//  mux_key      out  N_MUX    applied mux-LUT key
//  key_valid    out  1        applied key is authentic
//  load_err     out  1        1-cycle pulse: frame CRC mismatch
//  locked_out   out  1        permanent lockout indication
//  fail_cnt     out  FCW      consecutive failures, FCW = $clog2(MAX_FAILS+1)
// BEHAVIOUR
//  - Reset:
//    - state = IDLE.
//    - All outputs are 0; shadow register, CRC and bit counter are cleared.
//  - Frame format, LSB-first:
//    - N_XOR xor-key bits, then N_MUX mux-key bits (K = N_XOR+N_MUX bits).
//    - Then SIG_W signature bits, MSB-first.
//  - A bit transfers when key_in_valid && key_in_ready.
//    - key_in_ready = 1 only in LOAD.
//  - CRC over the K key bits, per transfer:
//    fb = crc[SIG_W-1] ^ bit; crc = {crc[SIG_W-2:0],1'b0} ^ (fb ? CRC_POLY : 0).
//  - States:
//    - IDLE: load_start -> LOAD, which clears shadow, CRC and counter.
//    - LOAD: shift key bits into the shadow register and CRC, then signature bits into
//      sig_reg. After transfer number K+SIG_W -> CHECK. No timeout; bubbles are allowed.
//    - CHECK, 1 cycle, ready = 0:
//      - match (sig_reg == crc): copy shadow to xor_key/mux_key, key_valid <= 1,
//        fail_cnt <= 0 -> ARMED.
//      - mismatch: load_err pulse, fail_cnt++, active key zeroised, key_valid <= 0.
//        Go to LOCKOUT if fail_cnt reaches MAX_FAILS, otherwise IDLE.
//    - ARMED: key held stable.
//      - load_start -> LOAD. The old key stays applied until the new frame's CHECK.
//    - LOCKOUT: absorbing until rst_n.
//      - locked_out = 1, key outputs 0, key_valid = 0, ready = 0.
//      - All inputs ignored.
//  - key_clr (any state except LOCKOUT):
//    - Zeroises xor_key, mux_key and shadow; key_valid <= 0 -> IDLE.
//    - fail_cnt is unchanged, and an aborted LOAD does not count as a failure.
//  - Simultaneous events:
//    - key_clr beats load_start, and key_clr beats a transfer in the same cycle.
//    - load_start during LOAD or CHECK is ignored.
//  - Output timing:
//    - Outputs are registered.
//    - Key outputs change only on the CHECK->ARMED edge, on key_clr, on a CHECK fail, or at reset.
//  - fail_cnt saturates at MAX_FAILS.
//  - Asynchronous reset mid-frame discards the partial frame.
// TESTING
//  - Golden load: xor=34'h2_5A5A_5A5A, mux=4'b1001, correct CRC.
//    -> key_valid=1 one cycle after the last bit; outputs equal the loaded values; fail_cnt=0.
//  - Corrupt one signature bit.
//    -> load_err pulses once; fail_cnt=1; keys=0; state returns to IDLE; a new load is accepted.
//  - 3 bad frames in a row (MAX_FAILS=3).
//    -> locked_out=1; key_in_ready stays 0; a later good frame is ignored until rst_n.
//  - key_clr at bit 20 of a frame while ARMED.
//    -> keys=0, key_valid=0, fail_cnt unchanged; the next good frame arms.
//  - Random key_in_valid gaps (50% duty), N_XOR=8, N_MUX=16, SIG_W=8.
//    -> result identical to the gap-free load.
//  - rst_n asserted mid-LOAD, then a good frame.
//    -> all outputs 0 during reset; the good frame arms normally.

Source files
------------

// File: rtl/key_lock_ctrl_if.sv
// Key-provisioning interface for key_lock_ctrl.
// Carries the frame control pulses and the serial bit handshake.
//   load_start   : pulse, begin a new key frame
//   key_clr      : pulse, zeroise the active key and abort any load
//   key_in_valid : serial bit valid
//   key_in_bit   : serial key/signature bit
//   key_in_ready : the key manager accepts a bit this cycle
interface key_lock_ctrl_if;
  logic load_start;
  logic key_clr;
  logic key_in_valid;
  logic key_in_bit;
  logic key_in_ready;

  modport master (
    output load_start,
    output key_clr,
    output key_in_valid,
    output key_in_bit,
    input  key_in_ready
  );

  modport slave (
    input  load_start,
    input  key_clr,
    input  key_in_valid,
    input  key_in_bit,
    output key_in_ready
  );
endinterface

// File: rtl/key_lock_ctrl.sv
// Sequential key manager for a logic-locked core (XOR key gates plus
// mux-LUT key cells). A serial frame of key bits (LSB-first) followed by a
// CRC signature (MSB-first) is received; the key is applied only if the CRC
// over the key bits matches the signature. Too many failed frames in a row
// cause a permanent lockout that only rst_n clears.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   kp           : key-provisioning interface (slave side)
//   xor_key_o    : applied XOR key
//   mux_key_o    : applied mux-LUT key
//   key_valid_o  : applied key is authentic
//   load_err_o   : 1-cycle pulse on a frame CRC mismatch
//   locked_out_o : permanent lockout indication
//   fail_cnt_o   : consecutive failed frames, saturating at MAX_FAILS
module key_lock_ctrl #(
  parameter int               N_XOR     = 34,
  parameter int               N_MUX     = 4,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] CRC_POLY  = 16'h1021,
  parameter int               MAX_FAILS = 3,
  localparam int              FCW       = $clog2(MAX_FAILS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  key_lock_ctrl_if.slave   kp,
  output logic [N_XOR-1:0] xor_key_o,
  output logic [N_MUX-1:0] mux_key_o,
  output logic             key_valid_o,
  output logic             load_err_o,
  output logic             locked_out_o,
  output logic [FCW-1:0]   fail_cnt_o
);

  localparam int K   = N_XOR + N_MUX;
  localparam int TOT = K + SIG_W;
  localparam int CW  = $clog2(TOT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [K-1:0]     shadow_q, shadow_d;
  logic [SIG_W-1:0] crc_q, crc_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_XOR-1:0] xor_q, xor_d;
  logic [N_MUX-1:0] mux_q, mux_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [FCW-1:0]   fail_q, fail_d;
  logic             ready_q, ready_d;
  logic             locked_q, locked_d;
  logic             xfer_s;

  // One serial CRC step: feedback is the register MSB xored with the new bit.
  function automatic logic [SIG_W-1:0] crc_step(input logic [SIG_W-1:0] c, input logic b);
    logic fb;
    fb = c[SIG_W-1] ^ b;
    return {c[SIG_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {SIG_W{1'b0}});
  endfunction

  assign xfer_s = kp.key_in_valid & ready_q;

  // Next-state and datapath update for the frame receiver and key outputs.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    crc_d    = crc_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    mux_d    = mux_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    fail_d   = fail_q;
    // key_clr wins over everything except the absorbing lockout.
    if (kp.key_clr && (state_q != ST_LOCKOUT)) begin
      state_d  = ST_IDLE;
      shadow_d = {K{1'b0}};
      xor_d    = {N_XOR{1'b0}};
      mux_d    = {N_MUX{1'b0}};
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ARMED: begin
          // The old key stays applied while a new frame is loaded.
          if (kp.load_start) begin
            state_d  = ST_LOAD;
            shadow_d = {K{1'b0}};
            crc_d    = {SIG_W{1'b1}};
            sig_d    = {SIG_W{1'b0}};
            cnt_d    = {CW{1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            if (cnt_q < CW'(K)) begin
              // Right shift: after K bits the first received bit sits at index 0.
              shadow_d = {kp.key_in_bit, shadow_q[K-1:1]};
              crc_d    = crc_step(crc_q, kp.key_in_bit);
            end else begin
              sig_d = {sig_q[SIG_W-2:0], kp.key_in_bit};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(TOT - 1)) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_CHECK: begin
          if (sig_q == crc_q) begin
            state_d = ST_ARMED;
            xor_d   = shadow_q[N_XOR-1:0];
            mux_d   = shadow_q[K-1:N_XOR];
            valid_d = 1'b1;
            fail_d  = {FCW{1'b0}};
          end else begin
            err_d   = 1'b1;
            xor_d   = {N_XOR{1'b0}};
            mux_d   = {N_MUX{1'b0}};
            valid_d = 1'b0;
            if (fail_q != FCW'(MAX_FAILS)) begin
              fail_d = fail_q + FCW'(1);
            end else begin
              fail_d = fail_q;
            end
            if (fail_q >= FCW'(MAX_FAILS - 1)) begin
              state_d = ST_LOCKOUT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_LOCKOUT: begin
          state_d = ST_LOCKOUT;
          xor_d   = {N_XOR{1'b0}};
          mux_d   = {N_MUX{1'b0}};
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Ready and lockout flags are registered decodes of the next state.
  always_comb begin
    ready_d  = (state_d == ST_LOAD);
    locked_d = (state_d == ST_LOCKOUT);
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= {K{1'b0}};
      crc_q    <= {SIG_W{1'b0}};
      sig_q    <= {SIG_W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      xor_q    <= {N_XOR{1'b0}};
      mux_q    <= {N_MUX{1'b0}};
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      fail_q   <= {FCW{1'b0}};
      ready_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      crc_q    <= crc_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      mux_q    <= mux_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      ready_q  <= ready_d;
      locked_q <= locked_d;
    end
  end

  assign kp.key_in_ready = ready_q;
  assign xor_key_o       = xor_q;
  assign mux_key_o       = mux_q;
  assign key_valid_o     = valid_q;
  assign load_err_o      = err_q;
  assign locked_out_o    = locked_q;
  assign fail_cnt_o      = fail_q;

endmodule
